// File: rtl/bus_interface_unit.sv
// Bus interface unit: one byte/word request over an 8-bit strobed memory bus.
// Define BIU_TIMEOUT_EN to abort byte cycles after WAIT_MAX wait states.
module bus_interface_unit #(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [19:0] req_addr,
  input  logic        req_write,
  input  logic        req_word,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  output logic [19:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_ale,
  output logic        mem_rd_n,
  output logic        mem_wr_n,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {
    IDLE, T1, T2, TW, T3, RESP
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] addr_q, addr_d;
  logic [7:0]  whi_q, whi_d;
  logic [7:0]  mwd_q, mwd_d;
  logic        write_q, write_d;
  logic        word_q, word_d;
  logic        hi_q, hi_d;
  logic [15:0] rbuf_q, rbuf_d;
  logic [15:0] rdata_q, rdata_d;
  logic        strobe;
  logic        timeout;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    whi_d   = whi_q;
    mwd_d   = mwd_q;
    write_d = write_q;
    word_d  = word_q;
    hi_d    = hi_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = T1;
          addr_d  = req_addr;
          write_d = req_write;
          word_d  = req_word;
          whi_d   = req_wdata[15:8];
          mwd_d   = req_write ? req_wdata[7:0] : 8'h00;
          hi_d    = 1'b0;
          rbuf_d  = '0;
        end
      end
      T1: state_d = T2;
      T2, TW: begin
        if (mem_ready) begin
          state_d = T3;
          if (!write_q) begin
            if (hi_q) rbuf_d[15:8] = mem_rdata;
            else      rbuf_d[7:0]  = mem_rdata;
          end
        end else if (timeout) begin
          // abort skips any remaining byte
          state_d = RESP;
          rdata_d = '0;
        end else begin
          state_d = TW;
        end
      end
      T3: begin
        if (word_q && !hi_q) begin
          state_d = T1;
          hi_d    = 1'b1;
          addr_d  = addr_q + 20'd1;
          if (write_q) mwd_d = whi_q;
        end else begin
          state_d = RESP;
          rdata_d = rbuf_q;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      whi_q   <= '0;
      mwd_q   <= '0;
      write_q <= 1'b0;
      word_q  <= 1'b0;
      hi_q    <= 1'b0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      whi_q   <= whi_d;
      mwd_q   <= mwd_d;
      write_q <= write_d;
      word_q  <= word_d;
      hi_q    <= hi_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef BIU_TIMEOUT_EN
  localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);

  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;

  assign timeout = (state_q == TW) && !mem_ready &&
                   (wait_q == WaitLast);

  always_comb begin
    wait_d = wait_q;
    err_d  = err_q;
    if (state_q == T1) begin
      wait_d = '0;
      err_d  = 1'b0;
    end else if (state_q == TW) begin
      wait_d = wait_q + 8'd1;
    end
    if (timeout) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign rsp_error = err_q && (state_q == RESP);
`else
  logic unused_wait_max;
  assign unused_wait_max = ^8'(WAIT_MAX);
  assign timeout   = 1'b0;
  assign rsp_error = 1'b0;
`endif

  assign strobe    = (state_q == T2) || (state_q == TW);
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = mwd_q;
  assign mem_ale   = (state_q == T1);
  assign mem_rd_n  = !(strobe && !write_q);
  assign mem_wr_n  = !(strobe && write_q);

endmodule

// File: doc/bus_interface_unit.md
# bus_interface_unit

Bus interface unit: the memory-side consumer of the 20-bit physical address produced by the address ALU. Accepts one read or write request (byte or 16-bit word) through a valid/ready handshake, runs one or two byte cycles on an 8-bit strobed memory bus with ready-driven wait states, and returns read data or write completion through a one-cycle response pulse. Sits between the execution unit's address/data path and external memory.

## Interface

- WAIT_MAX, 15: maximum consecutive wait cycles per byte cycle before abort; only used with BIU_TIMEOUT_EN; range 1..255.

- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept; high only in IDLE.
- req_addr  in  20  physical address of the first (low) byte.
- req_write  in  1  1 = write, 0 = read.
- req_word  in  1  1 = 16-bit access, 0 = byte.
- req_wdata  in  16  write data; bits [7:0] only for byte writes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  16  read data, valid with rsp_valid; byte reads zero-extend.
- rsp_error  out  1  timeout abort, valid with rsp_valid.
- mem_addr  out  20  byte address on the memory bus.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte.
- mem_ale  out  1  address latch enable, high in T1.
- mem_rd_n  out  1  read strobe, active-low.
- mem_wr_n  out  1  write strobe, active-low.
- mem_ready  in  1  memory ready; low inserts wait cycles.

## Operation

- Handshake: request accepted on a rising edge with req_valid && req_ready; req_addr, req_write, req_word, req_wdata are registered at acceptance and may then change.
- States: IDLE, T1, T2, TW, T3, RESP.
- IDLE -> T1 on acceptance.
- T1: mem_ale=1, mem_addr driven, strobes high; for writes mem_wdata driven from T1 through T3. Always -> T2.
- T2: mem_ale=0, selected strobe low. mem_ready=1 -> T3, else -> TW.
- TW: strobe stays low; -> T3 when mem_ready=1.
- Read data: mem_rdata captured on the edge leaving T2/TW with mem_ready=1.
- T3: strobes high, bus turnaround. If a second byte remains -> T1, else -> RESP.
- RESP: rsp_valid=1 for exactly one cycle, then -> IDLE.
- Word access: low byte at req_addr first, high byte at req_addr+1, little-endian. Address increment is modulo 2^20: 0xFFFFF wraps to 0x00000. No alignment requirement; even and odd addresses behave identically.
- Write bytes: req_wdata[7:0] first, then req_wdata[15:8].
- rsp_rdata holds its value until the next RESP. rsp_error is 0 except as specified under Configuration.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, mem_addr=0, mem_wdata=0, mem_ale=0, mem_rd_n=1, mem_wr_n=1, state IDLE.
- Reset asserted mid-access: immediate abort, outputs take reset values asynchronously, no response is generated.
- mem_ready is ignored outside T2/TW.

## Timing

- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- Zero-wait byte access: accept edge E; T1, T2, T3 in cycles E+1..E+3; rsp_valid in cycle E+4.
- Zero-wait word access: rsp_valid in cycle E+7.
- Each wait cycle adds one cycle.
- A new request is accepted no earlier than the edge ending RESP+1, i.e. the first cycle back in IDLE.

## Configuration

- BIU_TIMEOUT_EN defined:
  - An 8-bit wait counter clears in T1 and increments in each TW cycle.
  - When WAIT_MAX consecutive TW cycles pass without mem_ready, the unit deasserts the strobe, goes to RESP, and skips any remaining byte.
  - In that RESP: rsp_error=1, rsp_rdata=0.
- BIU_TIMEOUT_EN undefined:
  - No counter; the unit waits indefinitely in TW.
  - rsp_error is constant 0 and WAIT_MAX is unused.

## Test plan

- Byte read at 0x12345, mem_rdata=0xA5, mem_ready=1 -> one ALE pulse with mem_addr=0x12345, rd_n low one cycle, rsp_valid at E+4, rsp_rdata=0x00A5.
- Word write at 0xFFFFF, data 0xBEEF -> byte 0xEF at 0xFFFFF, then 0xBE at 0x00000, wr_n never low during T1/T3, rsp_valid at E+7, rsp_error=0.
- Word read at 0x00101 with mem_ready low 3 cycles on the first byte (0x34) and 0 on the second (0x12) -> rsp_rdata=0x1234, rsp_valid at E+10.
- req_valid held high through an access -> req_ready=0 from E+1 to RESP, the second request accepted only in IDLE with its own addresses.
- rst_n pulsed low during TW of a word write -> strobes high and ALE low immediately, no rsp_valid, req_ready=1 after release.
- With BIU_TIMEOUT_EN and WAIT_MAX=4, mem_ready stuck low on a word read -> exactly 4 TW cycles, no second byte cycle, rsp_valid with rsp_error=1 and rsp_rdata=0x0000.
